// File: rtl/alu_wb_pkg.sv
// Shared types for the ALU->writeback result queue: entry layout, "no exception" code
// and the exception test used by the barrier logic.
package alu_wb_pkg;

  localparam int ALU_WB_XLEN  = 32;
  localparam int ALU_WB_EXC_W = 4;
  localparam int ALU_WB_RA_W  = 5;

  localparam logic [ALU_WB_EXC_W-1:0] EXC_NONE = '0;

  typedef struct packed {
    logic                    wr_rd;
    logic [ALU_WB_RA_W-1:0]  rd_addr;
    logic [ALU_WB_XLEN-1:0]  rd;
    logic [ALU_WB_XLEN-1:0]  pc;
    logic [ALU_WB_EXC_W-1:0] exception;
  } alu_wb_entry_t;

  function automatic logic is_exc(input logic [ALU_WB_EXC_W-1:0] exc);
    return (exc != EXC_NONE);
  endfunction

endpackage

// File: rtl/alu_wb_entry_ram.sv
// Entry storage for the result queue: one synchronous write port, one asynchronous
// read port, no reset (validity is tracked by the queue's occupancy count).
module alu_wb_entry_ram
  import alu_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  alu_wb_entry_t            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output alu_wb_entry_t            rdata
);

  alu_wb_entry_t mem [DEPTH];

  // write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alu_wb_queue.sv
// alu_wb_queue: FIFO of completed ALU results ahead of writeback, with stall, flush and
// an exception barrier. Defining ALU_WB_BYPASS_EN adds same-cycle fall-through when empty.
module alu_wb_queue
  import alu_wb_pkg::*;
#(
  parameter int XLEN  = ALU_WB_XLEN,
  parameter int DEPTH = 2,
  parameter int EXC_W = ALU_WB_EXC_W,
  parameter int RA_W  = ALU_WB_RA_W
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_flush,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic                   i_wr_rd,
  input  logic [RA_W-1:0]        i_rd_addr,
  input  logic [XLEN-1:0]        i_rd,
  input  logic [XLEN-1:0]        i_pc,
  input  logic [EXC_W-1:0]       i_exception,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_wr_rd,
  output logic [RA_W-1:0]        o_rd_addr,
  output logic [XLEN-1:0]        o_rd,
  output logic [XLEN-1:0]        o_pc,
  output logic [EXC_W-1:0]       o_exception,
  output logic                   o_stall_from_q,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             barrier;
  logic             overflow;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic store;
  logic deq;
  logic bypass;
  logic out_valid;

  alu_wb_entry_t in_ent;
  alu_wb_entry_t head_ent;
  alu_wb_entry_t out_ent;

  assign in_ent = '{wr_rd: i_wr_rd, rd_addr: i_rd_addr, rd: i_rd, pc: i_pc, exception: i_exception};

  assign full    = (count == FULL_CNT);
  assign empty   = (count == CNT_W'(0));
  assign o_ready = ~full & ~barrier & ~i_rst;
  assign push    = i_valid & o_ready;

`ifdef ALU_WB_BYPASS_EN
  assign bypass = empty & push & ~i_flush;
`else
  assign bypass = 1'b0;
`endif

  assign out_valid = (~empty & ~i_rst) | bypass;
  assign pop       = out_valid & i_ready;
  // A bypassed entry consumed in the same cycle never touches storage.
  assign deq       = pop & ~empty;
  assign store     = push & ~i_flush & ~(bypass & i_ready);

  alu_wb_entry_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (i_clk),
    .we   (store),
    .waddr(wr_ptr),
    .wdata(in_ent),
    .raddr(rd_ptr),
    .rdata(head_ent)
  );

  // pointers, occupancy and exception barrier
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      barrier <= 1'b0;
    end else begin
      if (store) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({store, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // Only one exception entry can be queued, since the barrier blocks pushes behind it.
      if (store && is_exc(i_exception)) begin
        barrier <= 1'b1;
      end else if (deq && is_exc(head_ent.exception)) begin
        barrier <= 1'b0;
      end
    end
  end

  // sticky upstream-misuse flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      overflow <= 1'b0;
    end else if (i_valid && !o_ready) begin
      overflow <= 1'b1;
    end
  end

  // head selection; data outputs are zero whenever nothing is presented
  always_comb begin
    out_ent = '0;
    if (bypass) begin
      out_ent = in_ent;
    end else if (out_valid) begin
      out_ent = head_ent;
    end else begin
      out_ent = '0;
    end
  end

  assign o_valid        = out_valid;
  assign o_wr_rd        = out_ent.wr_rd & ~is_exc(out_ent.exception);
  assign o_rd_addr      = out_ent.rd_addr;
  assign o_rd           = out_ent.rd;
  assign o_pc           = out_ent.pc;
  assign o_exception    = out_ent.exception;
  assign o_stall_from_q = i_valid & ~o_ready & ~i_rst;
  assign o_count        = i_rst ? CNT_W'(0) : count;
  assign o_overflow     = overflow;

endmodule

// File: tb/tb_alu_wb_queue.sv
// Self-checking bench for alu_wb_queue: a DEPTH=2 and a DEPTH=4 instance share the same
// stimulus and are compared against a queue-based reference model.
module tb_alu_wb_queue;

  typedef struct packed {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] rd;
    logic [31:0] pc;
    logic [3:0]  exc;
  } ent_t;

`ifdef ALU_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, valid, wr_rd, rdy;
  logic [4:0]  rd_addr;
  logic [31:0] rd, pc;
  logic [3:0]  exc;

  logic        o_ready [2];
  logic        o_valid [2];
  logic        o_wr_rd [2];
  logic        o_stall [2];
  logic        o_ovf   [2];
  logic [4:0]  o_addr  [2];
  logic [31:0] o_rd    [2];
  logic [31:0] o_pc    [2];
  logic [3:0]  o_exc   [2];
  logic [2:0]  o_count [2];
  logic [1:0]  cnt2;
  logic [2:0]  cnt4;

  int n_checks = 0;
  int n_fail   = 0;

  ent_t mq [2][$];
  bit   ovf [2];
  int   dep [2] = '{2, 4};

  always #5 clk = ~clk;

  assign o_count[0] = {1'b0, cnt2};
  assign o_count[1] = cnt4;

  alu_wb_queue #(.DEPTH(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(o_ready[0]),
    .i_wr_rd(wr_rd), .i_rd_addr(rd_addr), .i_rd(rd), .i_pc(pc), .i_exception(exc),
    .o_valid(o_valid[0]), .i_ready(rdy), .o_wr_rd(o_wr_rd[0]), .o_rd_addr(o_addr[0]),
    .o_rd(o_rd[0]), .o_pc(o_pc[0]), .o_exception(o_exc[0]), .o_stall_from_q(o_stall[0]),
    .o_count(cnt2), .o_overflow(o_ovf[0])
  );

  alu_wb_queue #(.DEPTH(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(o_ready[1]),
    .i_wr_rd(wr_rd), .i_rd_addr(rd_addr), .i_rd(rd), .i_pc(pc), .i_exception(exc),
    .o_valid(o_valid[1]), .i_ready(rdy), .o_wr_rd(o_wr_rd[1]), .o_rd_addr(o_addr[1]),
    .o_rd(o_rd[1]), .o_pc(o_pc[1]), .o_exception(o_exc[1]), .o_stall_from_q(o_stall[1]),
    .o_count(cnt4), .o_overflow(o_ovf[1])
  );

  // ---------------- reference model ----------------
  function automatic ent_t cur_in();
    ent_t e;
    e.wr = wr_rd; e.addr = rd_addr; e.rd = rd; e.pc = pc; e.exc = exc;
    return e;
  endfunction

  function automatic bit has_exc(int k);
    for (int i = 0; i < mq[k].size(); i++) if (mq[k][i].exc != 4'd0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_ready(int k);
    return !rst && (mq[k].size() < dep[k]) && !has_exc(k);
  endfunction

  function automatic bit exp_byp(int k);
    return BYP && (mq[k].size() == 0) && valid && exp_ready(k) && !flush;
  endfunction

  function automatic bit exp_valid(int k);
    return !rst && ((mq[k].size() != 0) || exp_byp(k));
  endfunction

  function automatic ent_t exp_head(int k);
    ent_t e;
    e = '0;
    if (exp_valid(k)) e = (mq[k].size() != 0) ? mq[k][0] : cur_in();
    return e;
  endfunction

  function automatic int exp_count(int k);
    return rst ? 0 : mq[k].size();
  endfunction

  task automatic model_step(int k);
    bit r, v, byp;
    r = exp_ready(k); v = exp_valid(k); byp = exp_byp(k);
    if (rst) begin
      mq[k].delete(); ovf[k] = 1'b0;
    end else begin
      if (valid && !r) ovf[k] = 1'b1;
      if (flush) begin
        mq[k].delete();
      end else begin
        if (v && rdy && mq[k].size() != 0) void'(mq[k].pop_front());
        if (valid && r && !(byp && rdy)) mq[k].push_back(cur_in());
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic drive(input bit v, input logic [4:0] a, input logic [31:0] d, input logic [3:0] e);
    valid = v; wr_rd = 1'b1; rd_addr = a; rd = d; pc = d + 32'h1000; exc = e;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; rdy = 1'b0; valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; rdy = 1'b1;
    drive(1'b1, 5'd1, 32'h5A5A, 4'd0);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (o_ready[k] !== 1'b0) begin n_fail++; $display("FAIL reset_ready[%0d] got %0b want 0", k, o_ready[k]); end
      n_checks++; if (o_valid[k] !== 1'b0) begin n_fail++; $display("FAIL reset_valid[%0d] got %0b want 0", k, o_valid[k]); end
      n_checks++; if (o_count[k] !== 3'd0) begin n_fail++; $display("FAIL reset_count[%0d] got %0d want 0", k, o_count[k]); end
      n_checks++; if (o_stall[k] !== 1'b0) begin n_fail++; $display("FAIL reset_stall[%0d] got %0b want 0", k, o_stall[k]); end
      n_checks++; if (o_rd[k] !== 32'd0) begin n_fail++; $display("FAIL reset_rd[%0d] got %h want 0", k, o_rd[k]); end
    end
    tick(); tick();
    rst = 1'b0; valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (o_ovf[k] !== 1'b0) begin n_fail++; $display("FAIL post_reset_ovf[%0d] got %0b want 0", k, o_ovf[k]); end
      n_checks++; if (o_ready[k] !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready[%0d] got %0b want 1", k, o_ready[k]); end
      n_checks++; if (o_count[k] !== 3'd0) begin n_fail++; $display("FAIL post_reset_count[%0d] got %0d want 0", k, o_count[k]); end
    end
    tick();
  endtask

  task automatic test_order();
    do_reset();
    drive(1'b1, 5'd5, 32'h11, 4'd0); tick();
    drive(1'b1, 5'd6, 32'h22, 4'd0); tick();
    valid = 1'b0;
    @(negedge clk);
    n_checks++; if (o_count[0] !== 3'd2) begin n_fail++; $display("FAIL order_full_count got %0d want 2", o_count[0]); end
    n_checks++; if (o_ready[0] !== 1'b0) begin n_fail++; $display("FAIL order_full_ready got %0b want 0", o_ready[0]); end
    tick();
    rdy = 1'b1;
    @(negedge clk);
    n_checks++; if (o_rd[0] !== 32'h11 || o_addr[0] !== 5'd5) begin n_fail++; $display("FAIL order_A got %h/%0d want 11/5", o_rd[0], o_addr[0]); end
    n_checks++; if (o_count[0] !== 3'd2) begin n_fail++; $display("FAIL order_cnt2 got %0d want 2", o_count[0]); end
    tick();
    @(negedge clk);
    n_checks++; if (o_rd[0] !== 32'h22 || o_addr[0] !== 5'd6) begin n_fail++; $display("FAIL order_B got %h/%0d want 22/6", o_rd[0], o_addr[0]); end
    n_checks++; if (o_count[0] !== 3'd1) begin n_fail++; $display("FAIL order_cnt1 got %0d want 1", o_count[0]); end
    tick();
    @(negedge clk);
    n_checks++; if (o_count[0] !== 3'd0 || o_valid[0] !== 1'b0) begin n_fail++; $display("FAIL order_empty got cnt %0d valid %0b want 0 0", o_count[0], o_valid[0]); end
    n_checks++; if (o_rd[0] !== 32'd0) begin n_fail++; $display("FAIL order_idle_data got %h want 0", o_rd[0]); end
    tick();
  endtask

  task automatic test_full_overflow();
    do_reset();
    drive(1'b1, 5'd1, 32'hA1, 4'd0); tick();
    drive(1'b1, 5'd2, 32'hB2, 4'd0); tick();
    drive(1'b1, 5'd3, 32'hC3, 4'd0);
    @(negedge clk);
    n_checks++; if (o_stall[0] !== 1'b1) begin n_fail++; $display("FAIL full_stall got %0b want 1", o_stall[0]); end
    rdy = 1'b1;
    #1;
    n_checks++; if (o_ready[0] !== 1'b0) begin n_fail++; $display("FAIL full_ready_with_pop got %0b want 0", o_ready[0]); end
    tick();
    valid = 1'b0;
    @(negedge clk);
    n_checks++; if (o_ovf[0] !== 1'b1) begin n_fail++; $display("FAIL full_ovf got %0b want 1", o_ovf[0]); end
    n_checks++; if (o_count[0] !== 3'd1 || o_rd[0] !== 32'hB2) begin n_fail++; $display("FAIL full_after_pop got cnt %0d rd %h want 1 b2", o_count[0], o_rd[0]); end
    n_checks++; if (o_ovf[1] !== 1'b0 || o_count[1] !== 3'd2) begin n_fail++; $display("FAIL deep_accept got ovf %0b cnt %0d want 0 2", o_ovf[1], o_count[1]); end
    tick(); tick();
    flush = 1'b1; tick(); flush = 1'b0;
    @(negedge clk);
    n_checks++; if (o_ovf[0] !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %0b want 1", o_ovf[0]); end
    tick();
  endtask

  task automatic test_stream();
    do_reset();
    rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 5'(i), 32'(i), 4'd0);
      @(negedge clk);
      if (i > 0) begin
        n_checks++; if (o_rd[1] !== (BYP ? 32'(i) : 32'(i - 1))) begin n_fail++; $display("FAIL stream_data[%0d] got %0d", i, o_rd[1]); end
        n_checks++; if (o_count[1] !== (BYP ? 3'd0 : 3'd1)) begin n_fail++; $display("FAIL stream_count[%0d] got %0d", i, o_count[1]); end
      end
      tick();
    end
    valid = 1'b0;
    tick(); tick();
  endtask

  task automatic test_exception();
    do_reset();
    drive(1'b1, 5'd7, 32'hAA, 4'd2); tick();
    drive(1'b1, 5'd8, 32'hBB, 4'd0);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (o_ready[k] !== 1'b0) begin n_fail++; $display("FAIL exc_barrier[%0d] got %0b want 0", k, o_ready[k]); end
      n_checks++; if (o_wr_rd[k] !== 1'b0 || o_exc[k] !== 4'd2) begin n_fail++; $display("FAIL exc_head[%0d] got wr %0b exc %0d want 0 2", k, o_wr_rd[k], o_exc[k]); end
    end
    tick();
    rdy = 1'b1;
    #1;
    n_checks++; if (o_ready[1] !== 1'b0) begin n_fail++; $display("FAIL exc_ready_at_pop got %0b want 0", o_ready[1]); end
    tick();
    rdy = 1'b0;
    @(negedge clk);
    n_checks++; if (o_ready[1] !== 1'b1 || o_count[1] !== 3'd0) begin n_fail++; $display("FAIL exc_release got rdy %0b cnt %0d want 1 0", o_ready[1], o_count[1]); end
    tick();
    valid = 1'b0;
    @(negedge clk);
    n_checks++; if (o_rd[1] !== 32'hBB || o_wr_rd[1] !== 1'b1 || o_count[1] !== 3'd1) begin n_fail++; $display("FAIL exc_Y got rd %h wr %0b cnt %0d want bb 1 1", o_rd[1], o_wr_rd[1], o_count[1]); end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin drive(1'b1, 5'(i + 1), 32'h31 + 32'(i), 4'd0); tick(); end
    drive(1'b1, 5'd9, 32'h99, 4'd0);
    flush = 1'b1; rdy = 1'b1;
    tick();
    flush = 1'b0; valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (o_count[k] !== 3'd0 || o_valid[k] !== 1'b0) begin n_fail++; $display("FAIL flush[%0d] got cnt %0d valid %0b want 0 0", k, o_count[k], o_valid[k]); end
    end
    tick();
    @(negedge clk);
    n_checks++; if (o_valid[1] !== 1'b0) begin n_fail++; $display("FAIL flush_leak got valid %0b want 0", o_valid[1]); end
    tick();
  endtask

  task automatic test_latency();
    do_reset();
    rdy = 1'b1;
    drive(1'b1, 5'd3, 32'hABCD, 4'd0);
    @(negedge clk);
    n_checks++; if (o_valid[0] !== BYP || o_rd[0] !== (BYP ? 32'hABCD : 32'd0)) begin n_fail++; $display("FAIL lat_same got valid %0b rd %h", o_valid[0], o_rd[0]); end
    tick();
    valid = 1'b0;
    @(negedge clk);
    n_checks++; if (o_valid[0] !== !BYP || o_count[0] !== (BYP ? 3'd0 : 3'd1)) begin n_fail++; $display("FAIL lat_next got valid %0b cnt %0d", o_valid[0], o_count[0]); end
    tick();
  endtask

  task automatic test_random();
    ent_t h;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst   = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 19) == 0);
      rdy   = ($urandom_range(0, 1) == 1);
      drive($urandom_range(0, 3) != 0, 5'($urandom), $urandom, ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'd0);
      wr_rd = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        h = exp_head(k);
        n_checks++; if (o_valid[k] !== exp_valid(k)) begin n_fail++; $display("FAIL rnd_valid[%0d] c%0d got %0b want %0b", k, c, o_valid[k], exp_valid(k)); end
        n_checks++; if (o_ready[k] !== exp_ready(k)) begin n_fail++; $display("FAIL rnd_ready[%0d] c%0d got %0b want %0b", k, c, o_ready[k], exp_ready(k)); end
        n_checks++; if (o_count[k] !== 3'(exp_count(k))) begin n_fail++; $display("FAIL rnd_count[%0d] c%0d got %0d want %0d", k, c, o_count[k], exp_count(k)); end
        n_checks++; if (o_stall[k] !== (valid && !exp_ready(k) && !rst)) begin n_fail++; $display("FAIL rnd_stall[%0d] c%0d got %0b", k, c, o_stall[k]); end
        n_checks++; if (o_ovf[k] !== ovf[k]) begin n_fail++; $display("FAIL rnd_ovf[%0d] c%0d got %0b want %0b", k, c, o_ovf[k], ovf[k]); end
        n_checks++; if (o_rd[k] !== h.rd || o_pc[k] !== h.pc) begin n_fail++; $display("FAIL rnd_data[%0d] c%0d got %h/%h want %h/%h", k, c, o_rd[k], o_pc[k], h.rd, h.pc); end
        n_checks++; if (o_addr[k] !== h.addr || o_exc[k] !== h.exc) begin n_fail++; $display("FAIL rnd_addr_exc[%0d] c%0d got %0d/%0d want %0d/%0d", k, c, o_addr[k], o_exc[k], h.addr, h.exc); end
        n_checks++; if (o_wr_rd[k] !== (h.wr && h.exc == 4'd0)) begin n_fail++; $display("FAIL rnd_wr_rd[%0d] c%0d got %0b", k, c, o_wr_rd[k]); end
      end
      tick();
    end
    rst = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; rdy = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 4'd0);
    test_reset();
    test_order();
    test_full_overflow();
    test_reset();
    test_stream();
    test_exception();
    test_flush();
    test_latency();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
